// File: rtl/lcg_pcg_outbuf.sv
// -----------------------------------------------------------------------------
// lcg_pcg_outbuf
//
// Output stage for a 64-bit LCG state generator. Each accepted LCG word goes
// through the PCG XSH-RR permutation, which yields a 32-bit random word. After
// every reset the first DISCARD accepted words are dropped as warm-up. After
// that, results are queued in a DEPTH-entry FIFO and read out through a
// valid/ready handshake.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   DISCARD  accepted words dropped after each reset (0 = no warm-up)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    upstream word available
//   in_data     64-bit LCG state word
//   in_ready    block accepts in_data this cycle (registered)
//   out_valid   FIFO head holds a word (registered)
//   out_data    permuted word at FIFO head (registered)
//   out_ready   consumer takes the head word this cycle
//   fifo_level  current FIFO occupancy, 0..DEPTH
//   words_out   words delivered on the output handshake, wraps at 2^32
//   warm        high while in the warm-up state
// -----------------------------------------------------------------------------
module lcg_pcg_outbuf #(
  parameter int DEPTH   = 4,
  parameter int DISCARD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [63:0]              in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              words_out,
  output logic                     warm
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [0:0] ST_RESET  = (DISCARD > 0) ? ST_WARMUP : ST_RUN;

  localparam logic [CW-1:0] DISC_INIT = CW'(DISCARD);
  localparam logic [CW-1:0] DISC_ONE  = CW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  // XSH-RR permutation. Only x[63:27] affects the result, so the caller passes
  // just that slice. Bit i of hi equals x[27+i].
  //   t   = x[58:27] ^ (x >> 18)[58:27] = hi[31:0] ^ {13'b0, hi[36:18]}
  //   rot = x[63:59]                    = hi[36:32]
  // A right rotation is the low half of {t,t} shifted right by rot.
  function automatic logic [31:0] xsh_rr(input logic [36:0] hi);
    logic [31:0] t;
    logic [4:0]  rot;
    logic [63:0] dbl;
    t   = hi[31:0] ^ {13'b0, hi[36:18]};
    rot = hi[36:32];
    dbl = {t, t} >> rot;
    return dbl[31:0];
  endfunction

  logic [0:0]    state_q,     state_d;
  logic [CW-1:0] disc_q,      disc_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [LW-1:0] level_q,     level_d;
  logic [31:0]   words_q,     words_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q,  out_data_d;
  logic [31:0]   mem_q [DEPTH];

  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   perm_s;
  logic          unused_lsb_s;

  // The low 27 bits of the LCG word never reach the permuted output.
  assign unused_lsb_s = ^in_data[26:0];
  assign perm_s       = xsh_rr(in_data[63:27]);

  // Handshake qualifiers. in_ready_q is state-derived, so out_ready cannot
  // reach in_ready combinationally.
  always_comb begin
    accept_s = in_valid & in_ready_q;
    pop_s    = out_valid_q & out_ready;
  end

  // Next-state logic: warm-up countdown, FIFO pointers and level, counters.
  always_comb begin
    state_d  = state_q;
    disc_d   = disc_q;
    push_s   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    words_d  = words_q;

    case (state_q)
      ST_WARMUP: begin
        // Accepted words are consumed but never written to the FIFO.
        if (accept_s) begin
          disc_d = disc_q - DISC_ONE;
          if (disc_q == DISC_ONE) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WARMUP;
          end
        end else begin
          disc_d = disc_q;
        end
      end
      ST_RUN: begin
        push_s = accept_s;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      words_d  = words_q + 32'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
      words_d  = words_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Registered outputs are precomputed from next state. The head word can be
  // the word being pushed this edge: either the FIFO was empty, or its only
  // entry is being popped. In both cases the write pointer equals the new
  // read pointer.
  always_comb begin
    out_valid_d = (level_d != LVL_ZERO);
    if (level_d == LVL_ZERO) begin
      out_data_d = 32'h0000_0000;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = perm_s;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end

    if (state_d == ST_WARMUP) begin
      in_ready_d = 1'b1;
    end else begin
      in_ready_d = (level_d < LVL_FULL);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      disc_q      <= DISC_INIT;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= LVL_ZERO;
      words_q     <= 32'h0000_0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      disc_q      <= disc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      words_q     <= words_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // FIFO storage. Reset does not need to clear it because the pointers and
  // the level already define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= perm_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_level = level_q;
  assign words_out  = words_q;
  assign warm       = (state_q == ST_WARMUP);

endmodule

// File: tb/tb_lcg_pcg_outbuf.sv
module tb_lcg_pcg_outbuf;

  localparam int DEPTH   = 4;
  localparam int DISCARD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [31:0] words_out;
  logic        warm;

  logic        iv0;
  logic [63:0] id0;
  logic        ir0;
  logic        ov0;
  logic [31:0] od0;
  logic        or0;
  logic [2:0]  fl0;
  logic [31:0] wo0;
  logic        wm0;

  lcg_pcg_outbuf #(.DEPTH(DEPTH), .DISCARD(DISCARD)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fifo_level(fifo_level), .words_out(words_out),
    .warm(warm)
  );

  lcg_pcg_outbuf #(.DEPTH(DEPTH), .DISCARD(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0),
    .out_ready(or0), .fifo_level(fl0), .words_out(wo0), .warm(wm0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference permutation, written directly from the arithmetic definition.
  function automatic logic [31:0] perm(input logic [63:0] x);
    logic [31:0] t;
    int          r;
    t = 32'((x ^ (x >> 18)) >> 27);
    r = int'(x[63:59]);
    if (r == 0) return t;
    return (t >> r) | (t << (32 - r));
  endfunction

  // Behavioural model: a queue of expected words, a warm-up count and a pop count.
  bit          m_live = 1'b0;
  bit          m_warm;
  int          m_disc;
  logic [31:0] m_q[$];
  logic [31:0] m_cnt;
  logic [31:0] plog[$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_d;

  task automatic model_step();
    bit acc;
    bit pp;
    if (rst) begin
      m_live = 1'b1;
      m_q.delete();
      m_cnt  = 32'd0;
      m_disc = DISCARD;
      m_warm = (DISCARD > 0);
      pend_v = 1'b0;
    end else if (m_live) begin
      acc = in_valid && (m_warm || (m_q.size() < DEPTH));
      pp  = out_ready && (m_q.size() != 0);
      if (pend_v && out_ready) plog.push_back(pend_d);
      if (pp) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (acc) begin
        if (m_warm) begin
          m_disc--;
          if (m_disc == 0) m_warm = 1'b0;
        end else begin
          m_q.push_back(perm(in_data));
        end
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_live) begin
        chk("level",     64'(fifo_level), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid),  64'(m_q.size() != 0));
        chk("in_ready",  64'(in_ready),   64'(m_warm || (m_q.size() < DEPTH)));
        chk("warm",      64'(warm),       64'(m_warm));
        chk("words_out", 64'(words_out),  64'(m_cnt));
        if (m_q.size() != 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
      end
      pend_v = out_valid;
      pend_d = out_data;
    end
  end

  // Presents one word, which must be called at a negedge. The task returns at
  // the negedge after the edge that accepted the word.
  task automatic send(input logic [63:0] w);
    int t;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] word(input int i);
    logic [63:0] k;
    k = 64'h9E37_79B9_7F4A_7C15;
    return k * 64'(i + 1) + 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk_log(input string name, input int base, input int n);
    chk({name, "_count"}, 64'(plog.size()), 64'(n));
    for (int i = 0; i < n && i < plog.size(); i++)
      chk(name, 64'(plog[i]), 64'(perm(word(base + i))));
  endtask

  logic [63:0] vec [3];
  logic [31:0] vexp[3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    iv0 = 1'b0; id0 = 64'd0; or0 = 1'b1;

    // Hand-computed values that pin the model permutation.
    chk("perm_model_zero", 64'(perm(64'h0000_0000_0000_0000)), 64'h0000_0000);
    chk("perm_model_msb",  64'(perm(64'h8000_0000_0000_0000)), 64'h0000_0004);
    chk("perm_model_ones", 64'(perm(64'hFFFF_FFFF_FFFF_FFFF)), 64'hFFF0_0001);

    repeat (2) @(negedge clk);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_valid", 64'(out_valid),  64'd0);
    chk("rst_data",  64'(out_data),   64'd0);
    chk("rst_words", 64'(words_out),  64'd0);
    chk("rst_warm",  64'(warm),       64'd1);
    chk("rst_ready", 64'(in_ready),   64'd1);
    chk("rst0_warm", 64'(wm0),        64'd0);
    chk("rst0_ready", 64'(ir0),       64'd1);
    rst = 1'b0;

    // Permutation vectors on the instance without warm-up.
    vec[0] = 64'h0000_0000_0000_0000; vexp[0] = 32'h0000_0000;
    vec[1] = 64'h8000_0000_0000_0000; vexp[1] = 32'h0000_0004;
    vec[2] = 64'hFFFF_FFFF_FFFF_FFFF; vexp[2] = 32'hFFF0_0001;
    for (int i = 0; i < 3; i++) begin
      iv0 = 1'b1; id0 = vec[i];
      @(negedge clk);
      iv0 = 1'b0;
      chk("perm_valid", 64'(ov0), 64'd1);
      chk("perm_data",  64'(od0), 64'(vexp[i]));
      @(negedge clk);
      chk("perm_popped", 64'(ov0), 64'd0);
      chk("perm_words",  64'(wo0), 64'(i + 1));
    end

    // Warm-up: the first four words are dropped, and words 5 and 6 come out.
    out_ready = 1'b1;
    plog.delete();
    for (int i = 0; i < 6; i++) begin
      send(word(i));
      if (i < 3) begin
        chk("warmup_warm",  64'(warm),      64'd1);
        chk("warmup_valid", 64'(out_valid), 64'd0);
      end
      if (i == 3) chk("warmup_done", 64'(warm), 64'd0);
    end
    repeat (3) @(negedge clk);
    chk("warmup_words", 64'(words_out), 64'd2);
    chk_log("warmup_order", 4, 2);

    // Back-pressure: the FIFO fills to DEPTH and then drains in order.
    out_ready = 1'b0;
    plog.delete();
    fork
      for (int i = 0; i < 6; i++) send(word(10 + i));
      begin
        repeat (8) @(negedge clk);
        chk("bp_level", 64'(fifo_level), 64'd4);
        chk("bp_ready", 64'(in_ready),   64'd0);
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk_log("bp_order", 10, 6);
    chk("bp_words", 64'(words_out), 64'd8);

    // Full FIFO with continuous push and pop pressure.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(word(20 + i));
    chk("full_ready", 64'(in_ready),   64'd0);
    chk("full_level", 64'(fifo_level), 64'd4);
    plog.delete();
    out_ready = 1'b1;
    for (int i = 4; i < 12; i++) send(word(20 + i));
    repeat (8) @(negedge clk);
    chk_log("full_order", 20, 12);
    chk("full_words", 64'(words_out), 64'd20);

    // Reset in the middle of the stream flushes the FIFO and restarts warm-up.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(word(40 + i));
    chk("mid_level", 64'(fifo_level), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_valid", 64'(out_valid),  64'd0);
    chk("mid_rst_words", 64'(words_out),  64'd0);
    chk("mid_rst_warm",  64'(warm),       64'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(word(50 + i));
    chk("mid_disc_level", 64'(fifo_level), 64'd0);
    chk("mid_disc_warm",  64'(warm),       64'd0);
    send(word(54));
    chk("mid_first_data", 64'(out_data), 64'(perm(word(54))));
    repeat (2) @(negedge clk);
    chk("mid_words", 64'(words_out), 64'd1);

    // Wrap of the delivered-word counter.
    out_ready = 1'b0;
    send(word(60));
    send(word(61));
    plog.delete();
    force u_dut.words_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release u_dut.words_q;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_max",  64'(words_out), 64'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_zero", 64'(words_out), 64'd0);
    chk_log("wrap_data", 60, 2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog that stops a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
